// File: rtl/seq_alu_param.sv
// Parametrised sequential ALU. The opcode and operands arrive as DIN_W-bit
// beats on a valid/ready bus, and operands are assembled LSB beat first.
// Chaining lets the previous result become operand A. ADC and SBB consume
// the carry from the previous operation, so wide arithmetic can be built
// from a series of narrow operations.
module seq_alu_param #(
    parameter int WIDTH = 8,
    parameter int DIN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIN_W-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             chain_in,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             result_valid
);

    localparam int BEATS = WIDTH / DIN_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_NAND = 4'h6;
    localparam logic [3:0] OP_NOR  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_ASR  = 4'hA;
    localparam logic [3:0] OP_ADC  = 4'hB;
    localparam logic [3:0] OP_SBB  = 4'hC;
    localparam logic [3:0] OP_CMP  = 4'hD;
    localparam logic [3:0] OP_INC  = 4'hE;
    localparam logic [3:0] OP_DEC  = 4'hF;

    typedef enum logic [1:0] {
        GET_OP = 2'd0,
        GET_A  = 2'd1,
        GET_B  = 2'd2,
        EXEC   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             result_valid_q, result_valid_d;

    logic             accept;
    logic [WIDTH-1:0] opb;
    logic             cin;
    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic             add_v;
    logic             sub_v;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    // Unary ops take no B operand.
    function automatic logic is_unary(input logic [3:0] o);
        return (o == OP_NOT) || (o == OP_SHL) || (o == OP_SHR) ||
               (o == OP_ASR) || (o == OP_INC) || (o == OP_DEC);
    endfunction

    // The bus is closed in the EXEC cycle and while reset is held.
    assign din_ready = (state_q != EXEC) && !reset;
    assign accept    = din_valid && din_ready;

    assign result       = result_q;
    assign flags        = flags_q;
    assign result_valid = result_valid_q;

    // Shared adder and subtractor. INC and DEC reuse them with a constant 1.
    // ADC and SBB feed in the carry latched by the previous EXEC.
    always_comb begin
        opb = b_q;
        cin = 1'b0;
        if (op_q == OP_INC || op_q == OP_DEC) begin
            opb = WIDTH'(1);
        end
        if (op_q == OP_ADC || op_q == OP_SBB) begin
            cin = flags_q[1];
        end
        add_ext = {1'b0, a_q} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
        sub_ext = {1'b0, a_q} - {1'b0, opb} - {{WIDTH{1'b0}}, cin};
        add_v   = (a_q[MSB] == opb[MSB]) && (add_ext[MSB] != a_q[MSB]);
        sub_v   = (a_q[MSB] != opb[MSB]) && (sub_ext[MSB] != a_q[MSB]);
    end

    // Select the result, the carry/borrow and the overflow for the latched opcode.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OP_ADD, OP_ADC, OP_INC: begin
                alu_res = add_ext[WIDTH-1:0];
                alu_c   = add_ext[WIDTH];
                alu_v   = add_v;
            end
            OP_SUB, OP_SBB, OP_CMP, OP_DEC: begin
                alu_res = sub_ext[WIDTH-1:0];
                alu_c   = sub_ext[WIDTH];
                alu_v   = sub_v;
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_NOT:  alu_res = ~a_q;
            OP_NAND: alu_res = ~(a_q & b_q);
            OP_NOR:  alu_res = ~(a_q | b_q);
            OP_SHL: begin
                alu_res = {a_q[WIDTH-2:0], 1'b0};
                alu_c   = a_q[MSB];
            end
            OP_SHR: begin
                alu_res = {1'b0, a_q[WIDTH-1:1]};
                alu_c   = a_q[0];
            end
            OP_ASR: begin
                alu_res = {a_q[MSB], a_q[WIDTH-1:1]};
                alu_c   = a_q[0];
            end
            default: ;
        endcase
    end

    // Sequence through the opcode, A and B beats, then execute and write back.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        op_d           = op_q;
        a_d            = a_q;
        b_d            = b_q;
        result_d       = result_q;
        flags_d        = flags_q;
        result_valid_d = result_valid_q;
        case (state_q)
            GET_OP: begin
                if (accept) begin
                    op_d           = din[3:0];
                    result_valid_d = 1'b0;
                    cnt_d          = '0;
                    if (chain_in) begin
                        a_d     = result_q;
                        state_d = is_unary(din[3:0]) ? EXEC : GET_B;
                    end else begin
                        state_d = GET_A;
                    end
                end
            end
            GET_A: begin
                if (accept) begin
                    a_d[int'(cnt_q) * DIN_W +: DIN_W] = din;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = is_unary(op_q) ? EXEC : GET_B;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            GET_B: begin
                if (accept) begin
                    b_d[int'(cnt_q) * DIN_W +: DIN_W] = din;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = EXEC;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                // CMP updates the flags but leaves the result register untouched.
                if (op_q != OP_CMP) begin
                    result_d = alu_res;
                end
                flags_d        = {alu_res[MSB], (alu_res == '0), alu_c, alu_v};
                result_valid_d = 1'b1;
                state_d        = GET_OP;
            end
        endcase
    end

    // State register. An asynchronous reset aborts any partial operation at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= GET_OP;
            cnt_q          <= '0;
            op_q           <= '0;
            a_q            <= '0;
            b_q            <= '0;
            result_q       <= '0;
            flags_q        <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            op_q           <= op_d;
            a_q            <= a_d;
            b_q            <= b_d;
            result_q       <= result_d;
            flags_q        <= flags_d;
            result_valid_q <= result_valid_d;
        end
    end

endmodule
